// File: rtl/conv_frame_sequencer.sv
// Frame controller for the 5x5 convolution datapath: accepts host frames,
// places output pixels in frame memory and reports done, short or stalled frames.
module conv_frame_sequencer #(
  parameter int OUT_SIZE = 508,
  parameter int PIXEL    = 8,
  parameter int OADDR    = 18,
  parameter int TIMEOUT  = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_i,
  input  logic [OADDR-1:0]            base_i,
  output logic                        ready_o,
  output logic                        start_o,
  input  logic                        allow_i,
  input  logic [PIXEL-1:0]            pix_i,
  input  logic                        complete_i,
  output logic                        wr_en_o,
  output logic [OADDR-1:0]            wr_addr_o,
  output logic [PIXEL-1:0]            wr_data_o,
  output logic [$clog2(OUT_SIZE)-1:0] row_o,
  output logic [$clog2(OUT_SIZE)-1:0] col_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [1:0]                  err_code_o,
  input  logic                        clr_i
);

  localparam int RW = $clog2(OUT_SIZE);
  localparam int SW = (2 * RW > OADDR) ? 2 * RW : OADDR;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] LAST = RW'(OUT_SIZE - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_e;

  state_e            state_q;
  logic [OADDR-1:0]  base_q;
  logic [SW-1:0]     off_q;
  logic [RW-1:0]     row_q;
  logic [RW-1:0]     col_q;
  logic [WW-1:0]     wd_q;
  logic              start_q;
  logic              wr_en_q;
  logic [OADDR-1:0]  wr_addr_q;
  logic [PIXEL-1:0]  wr_data_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        code_q;

  logic              last_px;
  logic [SW-1:0]     sum;

  assign last_px = (row_q == LAST) && (col_q == LAST);
  // running linear offset replaces row*OUT_SIZE+col
  assign sum     = SW'(base_q) + off_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      base_q    <= '0;
      off_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wd_q      <= '0;
      start_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'b00;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            base_q  <= base_i;
            off_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wd_q    <= '0;
            start_q <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (allow_i) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= pix_i;
            wr_addr_q <= sum[OADDR-1:0];
            off_q     <= off_q + SW'(1);
            wd_q      <= '0;
            if (col_q == LAST) begin
              col_q <= '0;
              if (!last_px) row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end else if (wd_q != WD_MAX) begin
            wd_q <= wd_q + 1'b1;
          end
          if (allow_i && last_px) begin
            state_q <= DONE;
            start_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (complete_i) begin
            state_q <= ERR;
            start_q <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= 2'b01;
          end else if (!allow_i && wd_q == WD_MAX) begin
            state_q <= ERR;
            start_q <= 1'b0;
            err_q   <= 1'b1;
            code_q  <= 2'b10;
          end
        end
        DONE: state_q <= IDLE;
        ERR: begin
          if (clr_i) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o    = (state_q == IDLE);
  assign start_o    = start_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign row_o      = row_q;
  assign col_o      = col_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule
